// File: rtl/bbox_tracker.sv
// rtl/bbox_tracker.sv - per-frame bounding box and set-pixel count of a binary pixel stream
module bbox_tracker #(
    parameter int CNT_W     = 24,
    parameter int MIN_COUNT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [15:0]      width,
    input  logic [15:0]      height,
    input  logic             frame_sync,
    input  logic             in_write,
    input  logic             in_pixel,
    output logic             out_valid,
    output logic             found,
    output logic [15:0]      xmin,
    output logic [15:0]      xmax,
    output logic [15:0]      ymin,
    output logic [15:0]      ymax,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [63:0]      MIN_C   = 64'(MIN_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state, state_n;
    logic [15:0]       x, y, x_n, y_n;
    logic [15:0]       w_lat, h_lat, w_lat_n, h_lat_n;
    logic              hit, hit_n;
    logic [15:0]       acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [15:0]       acc_xmin_n, acc_xmax_n, acc_ymin_n, acc_ymax_n;
    logic [CNT_W-1:0]  acc_cnt, acc_cnt_n;
    logic              publish;

    // Working values of the current pixel slot
    logic              fresh;
    logic [15:0]       w_eff, h_eff, cx, cy;
    logic              take, at_eol, at_last;

    // State register; the rest of the FSM outputs live in the datapath block
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state, pixel position and accumulator update for this cycle
    always_comb begin
        // Outside ACCUM (or on a resync) the slot starts a new frame at (0,0)
        // with cleared accumulators and freshly sampled dimensions.
        fresh   = frame_sync || (state != ACCUM);
        w_eff   = fresh ? width  : w_lat;
        h_eff   = fresh ? height : h_lat;
        cx      = fresh ? 16'd0  : x;
        cy      = fresh ? 16'd0  : y;
        take    = in_write && (w_eff != 16'd0) && (h_eff != 16'd0);
        at_eol  = (cx == w_eff - 16'd1);
        at_last = at_eol && (cy == h_eff - 16'd1);

        state_n    = fresh ? IDLE : state;
        x_n        = cx;
        y_n        = cy;
        w_lat_n    = w_eff;
        h_lat_n    = h_eff;
        hit_n      = fresh ? 1'b0 : hit;
        acc_xmin_n = fresh ? 16'd0 : acc_xmin;
        acc_xmax_n = fresh ? 16'd0 : acc_xmax;
        acc_ymin_n = fresh ? 16'd0 : acc_ymin;
        acc_ymax_n = fresh ? 16'd0 : acc_ymax;
        acc_cnt_n  = fresh ? '0    : acc_cnt;
        publish    = 1'b0;

        if (take) begin
            if (at_last) begin
                state_n = DONE;
                x_n     = 16'd0;
                y_n     = 16'd0;
                publish = 1'b1;
            end else begin
                state_n = ACCUM;
                if (at_eol) begin
                    x_n = 16'd0;
                    y_n = cy + 16'd1;
                end else begin
                    x_n = cx + 16'd1;
                end
            end

            if (in_pixel) begin
                if (!hit_n) begin
                    acc_xmin_n = cx;
                    acc_xmax_n = cx;
                    acc_ymin_n = cy;
                    acc_ymax_n = cy;
                end else begin
                    if (cx < acc_xmin_n) acc_xmin_n = cx;
                    if (cx > acc_xmax_n) acc_xmax_n = cx;
                    if (cy < acc_ymin_n) acc_ymin_n = cy;
                    if (cy > acc_ymax_n) acc_ymax_n = cy;
                end
                hit_n = 1'b1;
                if (acc_cnt_n != CNT_MAX) acc_cnt_n = acc_cnt_n + CNT_ONE;
            end
        end
    end

    // Counters, accumulators and published results; results include the last pixel
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x         <= 16'd0;
            y         <= 16'd0;
            w_lat     <= 16'd0;
            h_lat     <= 16'd0;
            hit       <= 1'b0;
            acc_xmin  <= 16'd0;
            acc_xmax  <= 16'd0;
            acc_ymin  <= 16'd0;
            acc_ymax  <= 16'd0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            found     <= 1'b0;
            xmin      <= 16'd0;
            xmax      <= 16'd0;
            ymin      <= 16'd0;
            ymax      <= 16'd0;
            count     <= '0;
        end else begin
            x         <= x_n;
            y         <= y_n;
            w_lat     <= w_lat_n;
            h_lat     <= h_lat_n;
            hit       <= hit_n;
            acc_xmin  <= acc_xmin_n;
            acc_xmax  <= acc_xmax_n;
            acc_ymin  <= acc_ymin_n;
            acc_ymax  <= acc_ymax_n;
            acc_cnt   <= acc_cnt_n;
            out_valid <= publish;
            if (publish) begin
                xmin  <= acc_xmin_n;
                xmax  <= acc_xmax_n;
                ymin  <= acc_ymin_n;
                ymax  <= acc_ymax_n;
                count <= acc_cnt_n;
                found <= (64'(acc_cnt_n) >= MIN_C);
            end
        end
    end

endmodule

// File: tb/tb_bbox_tracker.sv
// tb/tb_bbox_tracker.sv - scoreboard bench for bbox_tracker
module tb_bbox_tracker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] width, height;
    logic        frame_sync, in_write, in_pixel;

    logic        out_valid, found;
    logic [15:0] xmin, xmax, ymin, ymax;
    logic [23:0] count;

    logic        b_out_valid, b_found;
    logic [15:0] b_xmin, b_xmax, b_ymin, b_ymax;
    logic [3:0]  b_count;

    typedef struct packed {
        logic [15:0] xmin;
        logic [15:0] xmax;
        logic [15:0] ymin;
        logic [15:0] ymax;
        logic [23:0] cnt;
        logic        found;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    always #5 clock = ~clock;

    bbox_tracker dut (
        .clock(clock), .reset_n(reset_n), .width(width), .height(height),
        .frame_sync(frame_sync), .in_write(in_write), .in_pixel(in_pixel),
        .out_valid(out_valid), .found(found), .xmin(xmin), .xmax(xmax),
        .ymin(ymin), .ymax(ymax), .count(count)
    );

    bbox_tracker #(.CNT_W(4), .MIN_COUNT(16)) dut_small (
        .clock(clock), .reset_n(reset_n), .width(width), .height(height),
        .frame_sync(frame_sync), .in_write(in_write), .in_pixel(in_pixel),
        .out_valid(b_out_valid), .found(b_found), .xmin(b_xmin), .xmax(b_xmax),
        .ymin(b_ymin), .ymax(b_ymax), .count(b_count)
    );

    // Scoreboard: every out_valid pulse consumes the oldest expected result
    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            res_t act;
            res_t e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got pulse, required none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                act = '{xmin, xmax, ymin, ymax, count, found};
                if (act !== e) begin
                    errors++;
                    $display("FAIL result: got x[%0d..%0d] y[%0d..%0d] cnt=%0d found=%0d, required x[%0d..%0d] y[%0d..%0d] cnt=%0d found=%0d",
                             act.xmin, act.xmax, act.ymin, act.ymax, act.cnt, act.found,
                             e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic res_t model(input int w, input int h, input logic [255:0] img);
        res_t r;
        bit   any;
        r   = '0;
        any = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (img[yy*w+xx]) begin
                    if (!any || xx < int'(r.xmin)) r.xmin = 16'(xx);
                    if (!any || xx > int'(r.xmax)) r.xmax = 16'(xx);
                    if (!any || yy < int'(r.ymin)) r.ymin = 16'(yy);
                    if (!any || yy > int'(r.ymax)) r.ymax = 16'(yy);
                    any   = 1;
                    r.cnt = r.cnt + 24'd1;
                end
            end
        end
        r.found = (r.cnt >= 24'd16);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_frame(input int w, input int h, input logic [255:0] img, input bit gaps);
        width  = 16'(w);
        height = 16'(h);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (gaps) begin
                    in_write = 1'b0;
                    tick($urandom_range(0, 2));
                end
                in_write = 1'b1;
                in_pixel = img[yy*w+xx];
                tick(1);
            end
        end
        in_write = 1'b0;
        in_pixel = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        frame_sync = 1'b0;
        in_write   = 1'b0;
        in_pixel   = 1'b0;
        width      = 16'd4;
        height     = 16'd3;
        tick(2);
        checks++;
        if (out_valid !== 1'b0 || found !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got out_valid=%0b found=%0b, required 0 0", out_valid, found);
        end
        checks++;
        if ({xmin, xmax, ymin, ymax} !== 64'd0) begin
            errors++;
            $display("FAIL reset_bbox: got %h, required 0", {xmin, xmax, ymin, ymax});
        end
        checks++;
        if (count !== 24'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", count);
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_hit();
        logic [255:0] img;
        int p0;
        img = '0;
        img[1*4+2] = 1'b1;
        p0 = pulses;
        exp_q.push_back(model(4, 3, img));
        drive_frame(4, 3, img, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t1_latency: got out_valid=%0b one cycle after last write, required 1", out_valid);
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_pulse_width: got out_valid=%0b, required 0", out_valid);
        end
        tick(3);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL t1_pulses: got %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_full_gaps();
        logic [255:0] img;
        int p0;
        img = '0;
        img[63:0] = '1;
        p0 = pulses;
        exp_q.push_back(model(8, 8, img));
        drive_frame(8, 8, img, 1);
        tick(4);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL t2_pulses: got %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_empty();
        int p0;
        p0 = pulses;
        exp_q.push_back(model(4, 4, '0));
        drive_frame(4, 4, '0, 0);
        tick(3);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL t3_pulses: got %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] img_a, img_b;
        int p0;
        img_a = '0;
        img_a[0] = 1'b1;
        img_b = '0;
        img_b[2*4+3] = 1'b1;
        p0 = pulses;
        exp_q.push_back(model(4, 3, img_a));
        exp_q.push_back(model(4, 3, img_b));
        drive_frame(4, 3, img_a, 0);
        drive_frame(4, 3, img_b, 0);
        tick(3);
        checks++;
        if (pulses - p0 !== 2) begin
            errors++;
            $display("FAIL t4_pulses: got %0d, required 2", pulses - p0);
        end
    endtask

    task automatic test_zero_dims();
        int p0;
        p0 = pulses;
        width  = 16'd0;
        height = 16'd3;
        in_write = 1'b1;
        in_pixel = 1'b1;
        tick(5);
        width  = 16'd4;
        height = 16'd0;
        tick(5);
        in_write = 1'b0;
        in_pixel = 1'b0;
        tick(2);
        checks++;
        if (pulses - p0 !== 0) begin
            errors++;
            $display("FAIL zero_dims_pulses: got %0d, required 0", pulses - p0);
        end
    endtask

    task automatic test_one_pixel();
        int p0;
        p0 = pulses;
        exp_q.push_back(model(1, 1, 256'd1));
        exp_q.push_back(model(1, 1, 256'd0));
        exp_q.push_back(model(1, 1, 256'd1));
        drive_frame(1, 1, 256'd1, 0);
        drive_frame(1, 1, 256'd0, 0);
        drive_frame(1, 1, 256'd1, 0);
        tick(3);
        checks++;
        if (pulses - p0 !== 3) begin
            errors++;
            $display("FAIL one_pixel_pulses: got %0d, required 3", pulses - p0);
        end
    endtask

    task automatic test_frame_sync();
        logic [255:0] img;
        int p0;
        p0 = pulses;
        width  = 16'd4;
        height = 16'd3;
        for (int i = 0; i < 5; i++) begin
            in_write = 1'b1;
            in_pixel = (i == 1);
            tick(1);
        end
        in_write   = 1'b0;
        in_pixel   = 1'b0;
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        img = '0;
        img[2*4+1] = 1'b1;
        exp_q.push_back(model(4, 3, img));
        drive_frame(4, 3, img, 0);
        tick(3);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL t5_pulses: got %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [255:0] img;
        int p0;
        width  = 16'd4;
        height = 16'd3;
        for (int i = 0; i < 6; i++) begin
            in_write = 1'b1;
            in_pixel = 1'b1;
            tick(1);
        end
        in_write = 1'b0;
        in_pixel = 1'b0;
        reset_n  = 1'b0;
        tick(1);
        checks++;
        if ({xmin, xmax, ymin, ymax} !== 64'd0 || count !== 24'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_reset_outputs: got bbox=%h count=%0d out_valid=%0b, required 0 0 0",
                     {xmin, xmax, ymin, ymax}, count, out_valid);
        end
        reset_n = 1'b1;
        tick(1);
        img = '0;
        img[63:0] = '1;
        p0 = pulses;
        exp_q.push_back(model(8, 8, img));
        drive_frame(8, 8, img, 0);
        tick(2);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL t6_pulses: got %0d, required 1", pulses - p0);
        end
        checks++;
        if (b_count !== 4'd15 || b_found !== 1'b0) begin
            errors++;
            $display("FAIL t6_saturate: got count=%0d found=%0b, required 15 0", b_count, b_found);
        end
        checks++;
        if ({b_xmin, b_xmax, b_ymin, b_ymax} !== {16'd0, 16'd7, 16'd0, 16'd7}) begin
            errors++;
            $display("FAIL t6_small_bbox: got x[%0d..%0d] y[%0d..%0d], required x[0..7] y[0..7]",
                     b_xmin, b_xmax, b_ymin, b_ymax);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_full_gaps();
        test_empty();
        test_back_to_back();
        test_zero_dims();
        test_one_pixel();
        test_frame_sync();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
